cpu6_trap_ctrl: RTL

//  Trap/return sequencer for the cpu6 core. Watches the Memory stage for ecall, illegal instruction,

---
 rtl/cpu6_trap_ctrl.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/cpu6_trap_ctrl.sv
// Trap/return sequencer for cpu6: takes M-stage exceptions, interrupts and mret, strobes CSR updates,
// flushes the pipe and redirects fetch. Optional vectored interrupt mode: CPU6_TRAP_VECTORED_EN.
module cpu6_trap_ctrl #(
   parameter int unsigned XLEN         = 32,
   parameter int unsigned EXT_IRQ_CODE = 11
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            validM,
   input  logic [XLEN-1:0] pcM,
   input  logic            ecallM,
   input  logic            illegalM,
   input  logic            mretM,
   input  logic            ext_irq,
   input  logic            mie_i,
   input  logic [XLEN-1:0] mtvec_i,
   input  logic [XLEN-1:0] mepc_i,
   output logic            flush_o,
   output logic            stallF_o,
   output logic            epc_we,
   output logic [XLEN-1:0] epc_wdat,
   output logic            cause_we,
   output logic [XLEN-1:0] cause_wdat,
   output logic            mstatus_trap,
   output logic            mstatus_mret,
   output logic            redirect_o,
   output logic [XLEN-1:0] redirect_pc,
   output logic            busy_o
);

   localparam logic [XLEN-1:0] CAUSE_ILLEGAL = XLEN'(2);
   localparam logic [XLEN-1:0] CAUSE_ECALL   = XLEN'(11);
   localparam logic [XLEN-1:0] CAUSE_IRQ     = {1'b1, (XLEN-1)'(EXT_IRQ_CODE)};

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_TRAP  = 2'd1,
      ST_RET   = 2'd2,
      ST_REDIR = 2'd3
   } state_e;

   state_e            state_q, state_d;
   logic              flush_q, flush_d;
   logic              stall_q, stall_d;
   logic              epc_we_q, epc_we_d;
   logic [XLEN-1:0]   epc_wdat_q, epc_wdat_d;
   logic              cause_we_q, cause_we_d;
   logic [XLEN-1:0]   cause_wdat_q, cause_wdat_d;
   logic              ms_trap_q, ms_trap_d;
   logic              ms_mret_q, ms_mret_d;
   logic              redirect_q, redirect_d;
   logic [XLEN-1:0]   redirect_pc_q, redirect_pc_d;
   logic              busy_q, busy_d;

   logic              trap_ev;
   logic              ret_ev;
   logic [XLEN-1:0]   ev_cause;
   logic [XLEN-1:0]   vec_base;
   logic [XLEN-1:0]   trap_target;

   // Event decode with fixed priority: illegal > ecall > enabled irq > mret
   always_comb begin
      trap_ev  = 1'b0;
      ret_ev   = 1'b0;
      ev_cause = '0;
      if (validM) begin
         if (illegalM) begin
            trap_ev  = 1'b1;
            ev_cause = CAUSE_ILLEGAL;
         end else if (ecallM) begin
            trap_ev  = 1'b1;
            ev_cause = CAUSE_ECALL;
         end else if (ext_irq && mie_i) begin
            trap_ev  = 1'b1;
            ev_cause = CAUSE_IRQ;
         end else if (mretM) begin
            ret_ev   = 1'b1;
         end
      end
   end

   assign vec_base = {mtvec_i[XLEN-1:2], 2'b00};

`ifdef CPU6_TRAP_VECTORED_EN
   // Interrupts in vectored mode land at base + 4*code; the latched cause is still valid in TRAP
   always_comb begin
      trap_target = vec_base;
      if ((mtvec_i[1:0] == 2'b01) && cause_wdat_q[XLEN-1]) begin
         trap_target = vec_base + {cause_wdat_q[XLEN-3:0], 2'b00};
      end
   end
`else
   logic unused_mode;
   assign trap_target = vec_base;
   assign unused_mode = ^mtvec_i[1:0];
`endif

   // Next state and next registered outputs; every output defaults to 0 (IDLE values)
   always_comb begin
      state_d       = state_q;
      flush_d       = 1'b0;
      stall_d       = 1'b0;
      epc_we_d      = 1'b0;
      epc_wdat_d    = '0;
      cause_we_d    = 1'b0;
      cause_wdat_d  = '0;
      ms_trap_d     = 1'b0;
      ms_mret_d     = 1'b0;
      redirect_d    = 1'b0;
      redirect_pc_d = '0;
      busy_d        = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (trap_ev) begin
               state_d      = ST_TRAP;
               flush_d      = 1'b1;
               stall_d      = 1'b1;
               epc_we_d     = 1'b1;
               epc_wdat_d   = pcM;
               cause_we_d   = 1'b1;
               cause_wdat_d = ev_cause;
               ms_trap_d    = 1'b1;
               busy_d       = 1'b1;
            end else if (ret_ev) begin
               state_d      = ST_RET;
               flush_d      = 1'b1;
               stall_d      = 1'b1;
               epc_wdat_d   = '0;
               ms_mret_d    = 1'b1;
               busy_d       = 1'b1;
            end
         end
         ST_TRAP: begin
            state_d       = ST_REDIR;
            redirect_d    = 1'b1;
            redirect_pc_d = trap_target;
            flush_d       = 1'b1;
            busy_d        = 1'b1;
         end
         ST_RET: begin
            state_d       = ST_REDIR;
            redirect_d    = 1'b1;
            redirect_pc_d = mepc_i;
            flush_d       = 1'b1;
            busy_d        = 1'b1;
         end
         ST_REDIR: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Synchronous reset abandons any trap in flight
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q       <= ST_IDLE;
         flush_q       <= 1'b0;
         stall_q       <= 1'b0;
         epc_we_q      <= 1'b0;
         epc_wdat_q    <= '0;
         cause_we_q    <= 1'b0;
         cause_wdat_q  <= '0;
         ms_trap_q     <= 1'b0;
         ms_mret_q     <= 1'b0;
         redirect_q    <= 1'b0;
         redirect_pc_q <= '0;
         busy_q        <= 1'b0;
      end else begin
         state_q       <= state_d;
         flush_q       <= flush_d;
         stall_q       <= stall_d;
         epc_we_q      <= epc_we_d;
         epc_wdat_q    <= epc_wdat_d;
         cause_we_q    <= cause_we_d;
         cause_wdat_q  <= cause_wdat_d;
         ms_trap_q     <= ms_trap_d;
         ms_mret_q     <= ms_mret_d;
         redirect_q    <= redirect_d;
         redirect_pc_q <= redirect_pc_d;
         busy_q        <= busy_d;
      end
   end

   assign flush_o      = flush_q;
   assign stallF_o     = stall_q;
   assign epc_we       = epc_we_q;
   assign epc_wdat     = epc_wdat_q;
   assign cause_we     = cause_we_q;
   assign cause_wdat   = cause_wdat_q;
   assign mstatus_trap = ms_trap_q;
   assign mstatus_mret = ms_mret_q;
   assign redirect_o   = redirect_q;
   assign redirect_pc  = redirect_pc_q;
   assign busy_o       = busy_q;

endmodule
